// File: rtl/single_proc_array.sv
// single_proc_array
//   Sequential 2-D convolution engine built around one multiply-accumulate
//   element. It convolves a 4x4 unsigned 8-bit tile A with a 3x3 unsigned
//   8-bit kernel B (valid correlation, stride 1, no kernel flip) into a 2x2
//   result C. One MAC is done per clock, so a full result takes 36 clocks.
//
//   Optional build macro: SINGLE_PROC_SAT_EN
//     defined   -> each 20-bit sum above 255 is clamped to 255
//     undefined -> the low 8 bits of each sum are output (modulo 256)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   active_single  level-sensitive start request; must drop to leave DONE
//   a11..a44       tile elements, aRC = row R, column C (sampled at start)
//   b11..b33       kernel weights, bRC = row R, column C (sampled at start)
//   done_single    high while the results are valid (DONE state)
//   c11..c22       registered 2x2 result, held until overwritten or reset
module single_proc_array (
  input  logic       clk,
  input  logic       rst,
  input  logic       active_single,
  input  logic [7:0] a11, a12, a13, a14,
  input  logic [7:0] a21, a22, a23, a24,
  input  logic [7:0] a31, a32, a33, a34,
  input  logic [7:0] a41, a42, a43, a44,
  input  logic [7:0] b11, b12, b13,
  input  logic [7:0] b21, b22, b23,
  input  logic [7:0] b31, b32, b33,
  output logic       done_single,
  output logic [7:0] c11, c12, c21, c22
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0][7:0]  a_q;    // a_q[{row,col}], 0-based
  logic [8:0][7:0]   b_q;    // b_q[tap], row-major
  logic [1:0]        k_q;    // output index: k[1] = row offset, k[0] = col offset
  logic [3:0]        t_q;    // tap index 0..8
  logic [19:0]       acc_q;
  logic [3:0][7:0]   c_q;

  // Tap -> kernel (row, col)
  logic [1:0] ti, tj;
  always_comb begin
    ti = 2'd0;
    tj = 2'd0;
    case (t_q)
      4'd0: begin ti = 2'd0; tj = 2'd0; end
      4'd1: begin ti = 2'd0; tj = 2'd1; end
      4'd2: begin ti = 2'd0; tj = 2'd2; end
      4'd3: begin ti = 2'd1; tj = 2'd0; end
      4'd4: begin ti = 2'd1; tj = 2'd1; end
      4'd5: begin ti = 2'd1; tj = 2'd2; end
      4'd6: begin ti = 2'd2; tj = 2'd0; end
      4'd7: begin ti = 2'd2; tj = 2'd1; end
      4'd8: begin ti = 2'd2; tj = 2'd2; end
      default: begin ti = 2'd0; tj = 2'd0; end
    endcase
  end

  // Tile coordinates never exceed 3, so 2-bit sums are exact.
  logic [1:0]  ar, ac;
  logic [7:0]  a_sel, b_sel;
  logic [15:0] prod;
  logic [19:0] sum;
  logic [7:0]  res;

  assign ar    = {1'b0, k_q[1]} + ti;
  assign ac    = {1'b0, k_q[0]} + tj;
  assign a_sel = a_q[{ar, ac}];
  assign b_sel = (t_q <= 4'd8) ? b_q[t_q] : 8'd0;
  assign prod  = a_sel * b_sel;
  // 9 * 255 * 255 < 2^20, so the accumulate cannot overflow.
  assign sum   = acc_q + {4'd0, prod};

`ifdef SINGLE_PROC_SAT_EN
  assign res = (sum > 20'd255) ? 8'hFF : sum[7:0];
`else
  assign res = sum[7:0];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (active_single)                    state_d = S_RUN;
      S_RUN:  if (t_q == 4'd8 && k_q == 2'd3)       state_d = S_DONE;
      S_DONE: if (!active_single)                   state_d = S_IDLE;
      default:                                      state_d = S_IDLE;
    endcase
  end

  // Output logic: done follows the registered state, so it is glitch-free
  // and rises on the same edge that writes c22.
  always_comb begin
    done_single = (state_q == S_DONE);
    c11 = c_q[0];
    c12 = c_q[1];
    c21 = c_q[2];
    c22 = c_q[3];
  end

  // Datapath: operand capture, counters, accumulator, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      t_q   <= '0;
      acc_q <= '0;
      c_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (active_single) begin
          a_q   <= {a44, a43, a42, a41, a34, a33, a32, a31,
                    a24, a23, a22, a21, a14, a13, a12, a11};
          b_q   <= {b33, b32, b31, b23, b22, b21, b13, b12, b11};
          k_q   <= '0;
          t_q   <= '0;
          acc_q <= '0;
        end
        S_RUN: begin
          if (t_q == 4'd8) begin
            // Last tap: the current product completes this output.
            c_q[k_q] <= res;
            acc_q    <= '0;
            t_q      <= '0;
            k_q      <= k_q + 2'd1;
          end else begin
            acc_q <= sum;
            t_q   <= t_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_single_proc_array.sv
module tb_single_proc_array;

  logic       clk;
  logic       rst;
  logic       active;
  logic [7:0] A [16];
  logic [7:0] B [9];
  logic       done;
  logic [7:0] c11, c12, c21, c22;

  int n_vec = 0;
  int n_err = 0;

  single_proc_array dut (
    .clk(clk), .rst(rst), .active_single(active),
    .a11(A[0]),  .a12(A[1]),  .a13(A[2]),  .a14(A[3]),
    .a21(A[4]),  .a22(A[5]),  .a23(A[6]),  .a24(A[7]),
    .a31(A[8]),  .a32(A[9]),  .a33(A[10]), .a34(A[11]),
    .a41(A[12]), .a42(A[13]), .a43(A[14]), .a44(A[15]),
    .b11(B[0]), .b12(B[1]), .b13(B[2]),
    .b21(B[3]), .b22(B[4]), .b23(B[5]),
    .b31(B[6]), .b32(B[7]), .b33(B[8]),
    .done_single(done),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Whole-result view: the four sums are computed outright at start, and
  // each output appears 9 clocks after the previous one.
  int         m_phase;   // 0 idle, 1 computing, 2 results valid
  int         m_cnt;
  int         m_res [4];
  logic [7:0] e_c [4];
  logic       e_done;

  function automatic int conv(int r, int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(A[(r + i) * 4 + c + j]) * int'(B[i * 3 + j]);
    return s;
  endfunction

  function automatic logic [7:0] nar(int s);
`ifdef SINGLE_PROC_SAT_EN
    return (s > 255) ? 8'd255 : 8'(s);
`else
    return 8'(s % 256);
`endif
  endfunction

  task automatic model_clear();
    m_phase = 0; m_cnt = 0; e_done = 1'b0;
    for (int k = 0; k < 4; k++) begin m_res[k] = 0; e_c[k] = 8'd0; end
  endtask

  task automatic model_step();
    if (rst) model_clear();
    else case (m_phase)
      0: if (active) begin
        for (int k = 0; k < 4; k++) m_res[k] = conv(k / 2, k % 2);
        m_cnt = 0; m_phase = 1;
      end
      1: begin
        m_cnt++;
        if (m_cnt % 9 == 0) e_c[m_cnt / 9 - 1] = nar(m_res[m_cnt / 9 - 1]);
        if (m_cnt == 36) begin m_phase = 2; e_done = 1'b1; end
      end
      default: if (!active) begin m_phase = 0; e_done = 1'b0; end
    endcase
  endtask

  // Per-cycle compare of every output against the model.
  task automatic check_all();
    n_vec++;
    if (done !== e_done || c11 !== e_c[0] || c12 !== e_c[1] ||
        c21 !== e_c[2] || c22 !== e_c[3]) begin
      n_err++;
      $display("FAIL cycle-compare t=%0t: got done=%0b c=%0d,%0d,%0d,%0d expected done=%0b c=%0d,%0d,%0d,%0d",
               $time, done, c11, c12, c21, c22, e_done, e_c[0], e_c[1], e_c[2], e_c[3]);
    end
  endtask

  // Hand-computed literal checks.
  task automatic lit(string name, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock: model observes the same edge as the DUT, outputs
  // are compared on the falling edge, and the bench drives at that point.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Issue a start and wait (bounded) for done; returns clocks from start edge.
  task automatic run(output int n);
    active = 1'b1;
    tick();
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (n >= 100) lit("done-timeout", n, 36);
  endtask

  task automatic load_ref();
    for (int i = 0; i < 16; i++) A[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++)  B[i] = 8'(i + 17);
  endtask

  task automatic load_const(logic [7:0] av, logic [7:0] bv);
    for (int i = 0; i < 16; i++) A[i] = av;
    for (int i = 0; i < 9; i++)  B[i] = bv;
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) A[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++)  B[i] = 8'($urandom_range(0, 255));
  endtask

  int n;

  initial begin
    model_clear();
    rst = 1'b1; active = 1'b0;
    load_const(8'd0, 8'd0);
    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    lit("reset-done", done, 0);
    lit("reset-c11", c11, 0);
    lit("reset-c22", c22, 0);

    // Pin the model against hand-computed sums
    load_ref();
    lit("model-sum00", conv(0, 0), 1212);
    lit("model-sum01", conv(0, 1), 1401);
    lit("model-sum10", conv(1, 0), 1968);
    lit("model-sum11", conv(1, 1), 2157);

    // Reference run
    run(n);
    lit("ref-latency", n, 36);
`ifdef SINGLE_PROC_SAT_EN
    lit("ref-c11", c11, 255); lit("ref-c12", c12, 255);
    lit("ref-c21", c21, 255); lit("ref-c22", c22, 255);
`else
    lit("ref-c11", c11, 188); lit("ref-c12", c12, 121);
    lit("ref-c21", c21, 176); lit("ref-c22", c22, 109);
`endif
    for (int i = 0; i < 4; i++) tick();   // stays in DONE while held
    lit("ref-done-held", done, 1);

    // Release: done clears, results hold
    active = 1'b0;
    tick();
    lit("release-done", done, 0);
`ifdef SINGLE_PROC_SAT_EN
    lit("release-c11-hold", c11, 255);
`else
    lit("release-c11-hold", c11, 188);
`endif

    // All ones; inputs scrambled mid-run must not matter
    load_const(8'd1, 8'd1);
    active = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    load_rand();
    active = 1'b0;                         // falling mid-run does not abort
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    lit("ones-c11", c11, 9); lit("ones-c12", c12, 9);
    lit("ones-c21", c21, 9); lit("ones-c22", c22, 9);
    tick();                                // active low -> back to IDLE
    lit("ones-idle", done, 0);

    // 255 * 1 everywhere: 2295
    load_const(8'd255, 8'd1);
    run(n);
    lit("max-latency", n, 36);
`ifdef SINGLE_PROC_SAT_EN
    lit("max-c11", c11, 255); lit("max-c22", c22, 255);
`else
    lit("max-c11", c11, 247); lit("max-c22", c22, 247);
`endif
    active = 1'b0; tick();

    // Restart with fresh data right after release
    load_rand();
    run(n);
    lit("rand-latency", n, 36);
    active = 1'b0; tick();

    // Reset 20 clocks into a run
    load_ref();
    active = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    #1;
    lit("midrst-done", done, 0);
    lit("midrst-c11", c11, 0);
    lit("midrst-c12", c12, 0);
    model_clear();
    active = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    lit("midrst-idle", done, 0);

    // Fresh run after reset
    load_const(8'd3, 8'd7);                // 9*21 = 189
    run(n);
    lit("post-rst-latency", n, 36);
    lit("post-rst-c21", c21, 189);
    active = 1'b0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/single_proc_array.md
# single_proc_array

Sequential 2-D convolution engine built around a single multiply-accumulate element. It convolves a 4x4 unsigned 8-bit input tile A with a 3x3 unsigned 8-bit kernel B (valid correlation, stride 1, no kernel flip) to produce a 2x2 result C. It sits in the datapath as the "single" (one-PE) variant of the process array: a controller raises `active_single`, then waits for `done_single`.

## Interface
- Parameters: none. All widths are fixed.
- `clk` input 1: the single clock; rising-edge active.
- `rst` input 1: reset, asynchronous and active-high.
- `active_single` input 1: start request, level-sensitive.
- `a11`…`a44` input 8 each: 16 tile elements; `aRC` is row R, column C.
- `b11`…`b33` input 8 each: 9 kernel weights; `bRC` is row R, column C.
- `done_single` output 1: result-valid flag.
- `c11`, `c12`, `c21`, `c22` output 8 each: registered 2x2 result.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE and clears all counters, the accumulator, `c11`–`c22` and `done_single` to 0.
- **IDLE → RUN**: taken on a rising edge where `active_single` is 1.
  - All 25 A and B inputs are captured into internal registers on that edge.
  - The output counter `k` and the tap counter `t` are set to 0.
  - The 20-bit accumulator is cleared.
- **RUN**: one MAC per clock, using the captured copies.
  - Output k=0..3 maps to (r,c) = (0,0),(0,1),(1,0),(1,1).
  - Tap t=0..8 maps to (i,j), row-major.
  - Each cycle computes acc += A[r+i][c+j] * B[i][j]: 8x8→16-bit product, 20-bit unsigned accumulate (no overflow possible).
  - When t=8, the final sum (acc plus the current product) is written to c[k]. The accumulator then restarts from 0 and k increments.
- Output narrowing: the default takes the low 8 bits (modulo 256). See Configuration for the alternative.
- **RUN → DONE**: taken on the edge that writes `c22`. `done_single` goes to 1 on that same edge.
- **DONE**:
  - `done_single` holds at 1 and `c11`–`c22` hold their values.
  - When `active_single` = 0 on an edge, the block returns to IDLE and `done_single` clears. `c*` keep their values.
  - If `active_single` stays high, the block remains in DONE. No automatic restart occurs.
- In IDLE, `c*` hold the last results (0 after reset).
- Input changes during RUN or DONE have no effect.
- `active_single` falling during RUN does not abort the computation.

## Timing
- Edge E0 is the IDLE edge that samples `active_single`=1.
- MACs are performed on edges E1–E36 (36 cycles).
- `c11`, `c12`, `c21` and `c22` update on E9, E18, E27 and E36 respectively.
- `done_single` = 1 after E36, so start-to-done latency is 36 clocks.
- The earliest restart is 2 edges after `active_single` falls: one edge to return to IDLE, one to start.
- Reset asserted at any time, including mid-RUN, immediately forces IDLE and zeroes all outputs and internal state. No partial results survive.

## Configuration
- `SINGLE_PROC_SAT_EN`
  - Defined: each 20-bit sum greater than 255 is clamped to 255; otherwise the sum passes through unchanged.
  - Undefined (default): the low 8 bits of the sum are output.
- Latency and handshake are identical in both builds.

## Test plan
- **Reset**: `rst`=1, then released with `active_single`=0 → all `c*`=0, `done_single`=0, and the block stays idle indefinitely.
- **Reference run**: A = 1..16 row-major, B = 17..25 row-major; release `rst`, then raise `active_single` and hold it.
  - Full sums are 1212, 1401, 1968, 2157.
  - Default build: `c11`=188, `c12`=121, `c21`=176, `c22`=109.
  - `done_single` rises exactly 36 clocks after the start edge and stays high.
- **Saturation build**: same stimulus with `SINGLE_PROC_SAT_EN` defined → all four outputs = 255.
- **Small values, no wrap**: all A=1, B=1 → every output is 9. With A=255 and B=1 everywhere, the default build gives 2295 mod 256 = 247.
- **Input capture and restart**: change A/B mid-RUN → results match the values captured at start. Then drop `active_single` → `done_single` clears, `c*` hold. Raise it again with new data → new results after 36 clocks.
- **Reset mid-run**: assert `rst` at cycle 20 of RUN → `c*`=0 and `done_single`=0 immediately. After release the block stays IDLE until the next `active_single`.
